// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream (length header + words)
// into 32-bit writes and holds the CPU in reset until the image is complete.
module imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 wr_en,
    output logic [31:0]          wr_addr,
    output logic [31:0]          wr_data,
    output logic                 cpu_reset_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err_overflow,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WR,
        S_DONE,
        S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [WORD_W-1:0]     n_q, n_d;
    logic [WORD_W-1:0]     shreg_q, shreg_d;
    logic                  ready_q, ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [WORD_W-1:0]     wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]     wr_data_q, wr_data_d;
    logic                  hold_q, hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  wc_q, wc_d;

    logic                  accept;
    logic [WORD_W-1:0]     hdr_in;
    logic [WORD_W-1:0]     word_in;
    logic [CNT_WIDTH-1:0]  wc_inc;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            n_q       <= '0;
            shreg_q   <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wc_q      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            shreg_q   <= shreg_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wc_q      <= wc_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        shreg_d   = shreg_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        wc_d      = wc_q;

        accept  = ready_q && byte_valid;
        hdr_in  = {n_q[23:0], byte_data};
        word_in = {shreg_q[23:0], byte_data};
        wc_inc  = wc_q + CNT_WIDTH'(1);

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_d = S_HDR;
                    idx_d   = 2'd0;
                    n_d     = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    wc_d    = '0;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_HDR: begin
                if (accept) begin
                    n_d   = hdr_in;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Full 32-bit length compare so oversized headers are never truncated
                        if (hdr_in == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            hold_d  = 1'b0;
                        end else if (hdr_in > WORD_W'(DEPTH)) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    shreg_d = word_in;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d   = S_WR;
                        wr_en_d   = 1'b1;
                        wr_addr_d = BASE_ADDR + (WORD_W'(wc_q) << 2);
                        wr_data_d = word_in;
                    end
                end
            end
            S_WR: begin
                wc_d = wc_inc;
                if (WORD_W'(wc_inc) == n_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    hold_d  = 1'b0;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_HDR) || (state_d == S_DATA);
    end

    assign byte_ready     = ready_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign cpu_reset_hold = hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_overflow   = err_q;
    assign word_count     = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load scenarios plus reset-mid-load sequence.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset_hold;
    logic        busy;
    logic        done;
    logic        err_overflow;
    logic [15:0] word_count;

    imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_reset_hold(cpu_reset_hold), .busy(busy), .done(done),
        .err_overflow(err_overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port log, appended by the monitor only
    int          wr_n = 0;
    logic [31:0] wr_a_log[$];
    logic [31:0] wr_d_log[$];
    int          wr_c_log[$];
    logic        wr_r_log[$];
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_a_log.push_back(wr_addr);
            wr_d_log.push_back(wr_data);
            wr_c_log.push_back(cyc);
            wr_r_log.push_back(byte_ready);
            wr_n = wr_n + 1;
        end
    end

    typedef struct {
        logic [127:0]     stream;
        int               nbytes;
        bit               throttle;
        int               restart_at;
        int               exp_wr;
        logic [2:0][31:0] exp_data;
        logic             exp_done;
        logic             exp_err;
        int               exp_wc;
    } ldvec_t;

    int checks = 0;
    int fails  = 0;
    bit tg     = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit thr);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        byte_data = b;
        while (!acc && guard < 64) begin
            byte_valid = thr ? tg : 1'b1;
            tg = ~tg;
            @(negedge clk);
            acc = byte_valid && byte_ready;
            step();
            load_start = 1'b0;
            guard++;
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL byte_timeout actual=not_accepted expected=accepted byte=%h", b);
        end
    endtask

    function automatic ldvec_t mk(input logic [127:0] s, input int nb, input bit thr,
                                  input int rs, input int ew, input logic [31:0] d0,
                                  input logic [31:0] d1, input logic [31:0] d2,
                                  input logic dn, input logic er, input int wc);
        ldvec_t v;
        v.stream      = s;
        v.nbytes      = nb;
        v.throttle    = thr;
        v.restart_at  = rs;
        v.exp_wr      = ew;
        v.exp_data[0] = d0;
        v.exp_data[1] = d1;
        v.exp_data[2] = d2;
        v.exp_done    = dn;
        v.exp_err     = er;
        v.exp_wc      = wc;
        return v;
    endfunction

    task automatic run_load(input ldvec_t v, input string tag);
        int base;
        int got;
        int guard;
        logic [7:0] b;
        base = wr_n;
        tg = 1'b1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int k = 0; k < v.nbytes; k++) begin
            if (k == v.restart_at) load_start = 1'b1;
            b = v.stream[127 - 8*k -: 8];
            send_byte(b, v.throttle);
        end
        byte_valid = 1'b0;
        if (v.nbytes == 4) begin
            chk({tag, "_done_next"}, 32'(done), 32'(v.exp_done));
            chk({tag, "_err_next"}, 32'(err_overflow), 32'(v.exp_err));
        end
        guard = 0;
        while (busy && guard < 20) begin
            step();
            guard++;
        end
        if (busy) begin
            checks++;
            fails++;
            $display("FAIL %s_busy_timeout actual=busy expected=idle", tag);
        end
        step();
        got = wr_n - base;
        chk({tag, "_nwrites"}, 32'(got), 32'(v.exp_wr));
        for (int i = 0; i < v.exp_wr && i < got; i++) begin
            chk({tag, "_addr"}, wr_a_log[base+i], 32'(4*i));
            chk({tag, "_data"}, wr_d_log[base+i], v.exp_data[i]);
            chk({tag, "_ready_in_wr"}, 32'(wr_r_log[base+i]), 32'd0);
            if (!v.throttle && i > 0)
                chk({tag, "_spacing"}, 32'(wr_c_log[base+i] - wr_c_log[base+i-1]), 32'd5);
        end
        if (v.exp_wr > 0)
            chk({tag, "_data_hold"}, wr_data, v.exp_data[v.exp_wr-1]);
        chk({tag, "_done"}, 32'(done), 32'(v.exp_done));
        chk({tag, "_err"}, 32'(err_overflow), 32'(v.exp_err));
        chk({tag, "_hold"}, 32'(cpu_reset_hold), 32'(!v.exp_done));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_wc"}, 32'(word_count), 32'(v.exp_wc));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctl"}, 32'({byte_ready, wr_en, cpu_reset_hold, busy, done, err_overflow}),
            32'(6'b001000));
        chk({tag, "_addr"}, wr_addr, 32'h0);
        chk({tag, "_data"}, wr_data, 32'h0);
        chk({tag, "_wc"}, 32'(word_count), 32'd0);
    endtask

    ldvec_t vec[7];

    initial begin
        vec[0] = mk({32'h0000_0002, 32'h2008_0005, 32'h0000_000C, 32'h0}, 12, 1'b0, -1, 2,
                    32'h2008_0005, 32'h0000_000C, 32'h0, 1'b1, 1'b0, 2);
        vec[1] = mk({32'h0000_0002, 32'h2008_0005, 32'h0000_000C, 32'h0}, 12, 1'b1, -1, 2,
                    32'h2008_0005, 32'h0000_000C, 32'h0, 1'b1, 1'b0, 2);
        vec[2] = mk({32'h0000_0101, 96'h0}, 4, 1'b0, -1, 0,
                    32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0);
        vec[3] = mk({32'h0000_0001, 32'hDEAD_BEEF, 64'h0}, 8, 1'b0, -1, 1,
                    32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 1'b0, 1);
        vec[4] = mk({32'h0000_0000, 96'h0}, 4, 1'b0, -1, 0,
                    32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 0);
        vec[5] = mk({32'h0000_0003, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC}, 16, 1'b0, -1, 3,
                    32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 1'b1, 1'b0, 3);
        vec[6] = mk({32'h0000_0002, 32'h2008_0005, 32'h0000_000C, 32'h0}, 12, 1'b0, 6, 2,
                    32'h2008_0005, 32'h0000_000C, 32'h0, 1'b1, 1'b0, 2);

        reset = 1'b1;
        step();
        step();
        chk_reset_state("reset");
        reset = 1'b0;
        step();

        for (int t = 0; t < 7; t++) begin
            run_load(vec[t], $sformatf("vec%0d", t));
        end

        // Reset mid-load after 6 bytes, colliding with a load_start
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send_byte(vec[0].stream[127 - 8*k -: 8], 1'b0);
        end
        chk("midload_busy", 32'(busy), 32'd1);
        reset      = 1'b1;
        load_start = 1'b1;
        byte_valid = 1'b1;
        step();
        chk_reset_state("midreset");
        reset      = 1'b0;
        load_start = 1'b0;
        byte_valid = 1'b0;
        step();
        chk("post_reset_idle", 32'({busy, byte_ready, cpu_reset_hold}), 32'(3'b001));
        run_load(vec[0], "reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that writes the instruction memory, which the CPU otherwise only reads through the PC.
- Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instruction words.
- Issues one write pulse per word to the instruction-memory write port.
- Holds the CPU (PC and friends) in reset until the image has been completely written.

Parameters:
- DEPTH, 256, instruction-memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word aligned.
- CNT_WIDTH, 16, width of the word counter and of the word_count output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  single-cycle pulse that begins a load; honoured only when busy=0.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the word being written (word aligned).
- wr_data  output  32  instruction word being written.
- cpu_reset_hold  output  1  drives the CPU reset (OR'd with the system reset).
- busy  output  1  a load is in progress.
- done  output  1  the last load completed successfully.
- err_overflow  output  1  the header word count exceeded DEPTH.
- word_count  output  CNT_WIDTH  number of words written so far in the current or last load.

Behaviour:
- Reset state: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset_hold=1, busy=0, done=0, err_overflow=0, word_count=0, byte index=0, header N=0.
- Reset asserted mid-load aborts the load immediately and returns to the full reset state. Partially written memory is not cleared.
- A byte is transferred only in a cycle where byte_valid=1 and byte_ready=1.
- byte_ready is 1 only in the HDR and DATA states.
- Stream format: 4 header bytes forming N (big-endian, first byte = bits 31:24), then N words of 4 bytes each, also big-endian.

States:
- IDLE: wait for load_start. On load_start: clear done, err_overflow and word_count, set cpu_reset_hold=1 and busy=1, then go to HDR.
- HDR: accept 4 bytes into N.
  - On acceptance of the 4th byte, the next state is chosen by N:
  - N=0 → DONE.
  - N>DEPTH → ERR.
  - Otherwise → DATA.
  - Compare all 32 bits of N; do not truncate to CNT_WIDTH.
- DATA: accept 4 bytes into a shift register. On the 4th byte → WR.
- WR (exactly 1 cycle):
  - Drive wr_en=1, wr_addr=BASE_ADDR + 4*word_count, wr_data=assembled word, byte_ready=0.
  - word_count increments at the end of this cycle.
  - If the new word_count equals N → DONE, else → DATA.
- DONE: done=1, busy=0, cpu_reset_hold=0. Remain here until load_start, which restarts as from IDLE.
- ERR: err_overflow=1, busy=0, cpu_reset_hold stays 1. Remain here until load_start restarts the load.

Timing and boundary rules:
- Throughput is 5 cycles per word with byte_valid held high: 4 accept cycles plus 1 WR cycle.
- wr_addr and wr_data hold their last values when wr_en=0. They are registered outputs, not combinational.
- load_start while busy=1 is ignored.
- load_start arriving in the same cycle as reset: reset wins.
- byte_valid while byte_ready=0 is not consumed; the source must hold the byte.
- The byte index wraps 3→0 per word. word_count never exceeds N, and N never exceeds DEPTH.
- N=DEPTH is legal: the final wr_addr is BASE_ADDR + 4*(DEPTH-1).

Test Plan:
1. Basic load: reset 2 cycles, load_start, stream 00 00 00 02, 20 08 00 05, 00 00 00 0C, byte_valid held high. Expect:
   - wr_en pulses twice, 5 cycles apart.
   - First pulse: wr_addr=0, wr_data=32'h20080005.
   - Second pulse: wr_addr=4, wr_data=32'h0000000C.
   - After the second pulse: done=1, cpu_reset_hold=0, word_count=2.
2. Throttled source: same stream as test 1 with byte_valid toggling 1/0 every cycle. Expect identical writes and values; no byte lost or duplicated; byte_ready=0 in every WR cycle.
3. Overflow: DEPTH=256, header 00 00 01 01 (N=257). Expect:
   - err_overflow=1 the cycle after the 4th header byte.
   - No wr_en.
   - cpu_reset_hold stays 1 and busy=0.
   - A following load_start with N=1 clears the error and completes.
4. Empty image: header 00 00 00 00. Expect done=1 and cpu_reset_hold=0 one cycle after the 4th header byte, word_count=0, no wr_en.
5. Reset mid-load: assert reset after 6 bytes of the test-1 stream. Expect:
   - The next cycle shows all outputs at reset values (cpu_reset_hold=1, word_count=0, byte_ready=0).
   - A new load_start with the full stream reproduces test 1.
6. Ignored restart: pulse load_start during DATA in test 1. Expect no effect; the writes match test 1 exactly.
